// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception cause codes, FSM state
// encoding and register reset values. Imported by cp0 and the control unit.
package cp0_pkg;

  // CP0 register numbers as seen by mtc0/mfc0
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Exception cause codes carried on ex_code
  localparam logic [4:0] EX_CODE_INT    = 5'd0;
  localparam logic [4:0] EX_CODE_HLT    = 5'd1;
  localparam logic [4:0] EX_CODE_RESUME = 5'd2;

  // Status: IE=1, EXL=0, IM all ones
  localparam logic       STATUS_IE_RESET  = 1'b1;
  localparam logic       STATUS_EXL_RESET = 1'b0;
  localparam logic [7:0] STATUS_IM_RESET  = 8'hFF;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StExc    = 2'd1,
    StHalt   = 2'd2,
    StResume = 2'd3
  } cp0_state_e;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: Status/Cause/EPC registers plus the exception/halt/eret
// sequencer that redirects the pipeline.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   ex, ex_code       exception request and cause (INT, HLT, RESUME)
//   cp0_we, cp0_rdc,  mtc0 write enable, register number (also the read
//   wdata             select for rdata) and write data
//   eret_flush        eret request
//   branch_delay      current instruction sits in a delay slot
//   pc_in             PC of the requesting instruction
//   ext_int           raw interrupt lines, sampled into Cause.IP each cycle
//   rdata             combinational read of the register selected by cp0_rdc
//   ex_wb, cp0_flush, registered pipeline redirect controls
//   cp0_hlt, cp0_eret
//   exc_pc            redirect target, valid with ex_wb/cp0_hlt/cp0_eret
//   cp0_ie, cp0_exl,  Status.IE, Status.EXL, Status.IM, Cause.IP
//   cp0_int_mask,
//   cp0_int_sig
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] HLT_VECTOR = 32'h0000_4200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex,
  input  logic [4:0]  ex_code,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_rdc,
  input  logic [31:0] wdata,
  input  logic        eret_flush,
  input  logic        branch_delay,
  input  logic [31:0] pc_in,
  input  logic [7:0]  ext_int,
  output logic [31:0] rdata,
  output logic        ex_wb,
  output logic        cp0_flush,
  output logic        cp0_hlt,
  output logic        cp0_eret,
  output logic        cp0_ie,
  output logic        cp0_exl,
  output logic [7:0]  cp0_int_mask,
  output logic [7:0]  cp0_int_sig,
  output logic [31:0] exc_pc
);

  cp0_state_e state_q, state_d;

  // Architectural register fields
  logic        status_ie_q;
  logic        status_exl_q;
  logic [7:0]  status_im_q;
  logic [4:0]  cause_exccode_q;
  logic [7:0]  cause_ip_q;
  logic        cause_bd_q;
  logic [31:0] epc_q;

  // Accepted requests, already priority-resolved
  logic take_int, take_hlt, take_resume, take_eret, take_mtc0, ex_taken;

  // Next values of the registered redirect outputs
  logic        ex_wb_d, cp0_flush_d, cp0_hlt_d, cp0_eret_d;
  logic [31:0] exc_pc_d;

  logic [31:0] epc_save;

  always_comb begin
    // ex is never accepted while the EXC redirect is in flight
    take_int    = (state_q == StRun) && ex && !ex_wb && (ex_code == EX_CODE_INT);
    take_hlt    = (state_q == StRun) && ex && !ex_wb && (ex_code == EX_CODE_HLT);
    take_resume = (state_q == StHalt) && ex &&
                  ((ex_code == EX_CODE_HLT) || (ex_code == EX_CODE_RESUME));
    ex_taken    = take_int || take_hlt || take_resume;
    take_eret   = (state_q == StRun) && eret_flush && !ex_taken;
    take_mtc0   = cp0_we && !ex_taken && !take_eret;
    // A delay-slot instruction restarts at its branch
    epc_save    = branch_delay ? (pc_in - 32'd4) : pc_in;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (take_int) begin
          state_d = StExc;
        end else if (take_hlt) begin
          state_d = StHalt;
        end else if (take_eret) begin
          // eret shares the one-cycle RESUME redirect
          state_d = StResume;
        end
      end
      StExc:    state_d = StRun;
      StHalt:   if (take_resume) state_d = StResume;
      StResume: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the next state so they land in flops together
  // with the state itself
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_wb_d     = 1'b0;
    cp0_flush_d = 1'b0;
    cp0_hlt_d   = 1'b0;
    cp0_eret_d  = 1'b0;
    exc_pc_d    = 32'h0;
    unique case (state_d)
      StExc: begin
        ex_wb_d     = 1'b1;
        cp0_flush_d = 1'b1;
        exc_pc_d    = EXC_VECTOR;
      end
      StHalt: begin
        cp0_hlt_d = 1'b1;
        exc_pc_d  = HLT_VECTOR;
      end
      StResume: begin
        cp0_eret_d  = 1'b1;
        cp0_flush_d = 1'b1;
        // EPC cannot change in the same cycle: mtc0 loses to eret/resume
        exc_pc_d    = epc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wb     <= 1'b0;
      cp0_flush <= 1'b0;
      cp0_hlt   <= 1'b0;
      cp0_eret  <= 1'b0;
      exc_pc    <= 32'h0;
    end else begin
      ex_wb     <= ex_wb_d;
      cp0_flush <= cp0_flush_d;
      cp0_hlt   <= cp0_hlt_d;
      cp0_eret  <= cp0_eret_d;
      exc_pc    <= exc_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      status_ie_q  <= STATUS_IE_RESET;
      status_exl_q <= STATUS_EXL_RESET;
      status_im_q  <= STATUS_IM_RESET;
    end else if (take_int || take_hlt) begin
      status_exl_q <= 1'b1;
    end else if (take_resume || take_eret) begin
      status_exl_q <= 1'b0;
    end else if (take_mtc0 && (cp0_rdc == CP0_REG_STATUS)) begin
      status_ie_q  <= wdata[0];
      status_exl_q <= wdata[1];
      status_im_q  <= wdata[15:8];
    end
  end

  // ---------------------------------------------------------------------------
  // Cause: IP tracks ext_int every cycle; mtc0 never touches Cause
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_exccode_q <= 5'd0;
      cause_ip_q      <= 8'h0;
      cause_bd_q      <= 1'b0;
    end else begin
      cause_ip_q <= ext_int;
      if (take_int || take_hlt) begin
        cause_exccode_q <= ex_code;
        cause_bd_q      <= branch_delay;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // EPC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= 32'h0;
    end else if (take_int || take_hlt) begin
      epc_q <= epc_save;
    end else if (take_mtc0 && (cp0_rdc == CP0_REG_EPC)) begin
      epc_q <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 32'h0;
    unique case (cp0_rdc)
      CP0_REG_STATUS: rdata = {16'h0, status_im_q, 6'h0, status_exl_q, status_ie_q};
      CP0_REG_CAUSE:  rdata = {cause_bd_q, 15'h0, cause_ip_q, 1'b0, cause_exccode_q, 2'b00};
      CP0_REG_EPC:    rdata = epc_q;
      default:        rdata = 32'h0;
    endcase
  end

  assign cp0_ie       = status_ie_q;
  assign cp0_exl      = status_exl_q;
  assign cp0_int_mask = status_im_q;
  assign cp0_int_sig  = cause_ip_q;

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0. Inputs change on the falling edge; outputs are
// sampled on the following falling edge.
module tb_cp0;

  logic        clk;
  logic        rst;
  logic        ex;
  logic [4:0]  ex_code;
  logic        cp0_we;
  logic [4:0]  cp0_rdc;
  logic [31:0] wdata;
  logic        eret_flush;
  logic        branch_delay;
  logic [31:0] pc_in;
  logic [7:0]  ext_int;
  logic [31:0] rdata;
  logic        ex_wb, cp0_flush, cp0_hlt, cp0_eret;
  logic        cp0_ie, cp0_exl;
  logic [7:0]  cp0_int_mask, cp0_int_sig;
  logic [31:0] exc_pc;

  int n_cmp = 0;
  int n_bad = 0;

  cp0 #(
    .EXC_VECTOR(32'h0000_4180),
    .HLT_VECTOR(32'h0000_4200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex           (ex),
    .ex_code      (ex_code),
    .cp0_we       (cp0_we),
    .cp0_rdc      (cp0_rdc),
    .wdata        (wdata),
    .eret_flush   (eret_flush),
    .branch_delay (branch_delay),
    .pc_in        (pc_in),
    .ext_int      (ext_int),
    .rdata        (rdata),
    .ex_wb        (ex_wb),
    .cp0_flush    (cp0_flush),
    .cp0_hlt      (cp0_hlt),
    .cp0_eret     (cp0_eret),
    .cp0_ie       (cp0_ie),
    .cp0_exl      (cp0_exl),
    .cp0_int_mask (cp0_int_mask),
    .cp0_int_sig  (cp0_int_sig),
    .exc_pc       (exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] exp);
    cp0_rdc = r;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; ex = 1'b0; ex_code = 5'd0; cp0_we = 1'b0; cp0_rdc = 5'd0;
    wdata = 32'h0; eret_flush = 1'b0; branch_delay = 1'b0; pc_in = 32'h0;
    ext_int = 8'h00;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    rd(5'd12, "rst_status", 32'h0000_FF01);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    rd(5'd7, "unimpl_reg", 32'h0);
    check("rst_ex_wb", {31'h0, ex_wb}, 32'h0);
    check("rst_hlt", {31'h0, cp0_hlt}, 32'h0);
    check("rst_eret", {31'h0, cp0_eret}, 32'h0);
    check("rst_ie", {31'h0, cp0_ie}, 32'h1);
    check("rst_im", {24'h0, cp0_int_mask}, 32'hFF);

    // Interrupt exception in a delay slot
    ex = 1'b1; ex_code = 5'd0; pc_in = 32'h0000_3010; branch_delay = 1'b1;
    step();
    ex = 1'b0; branch_delay = 1'b0;
    check("int_ex_wb", {31'h0, ex_wb}, 32'h1);
    check("int_flush", {31'h0, cp0_flush}, 32'h1);
    check("int_exc_pc", exc_pc, 32'h0000_4180);
    check("int_exl", {31'h0, cp0_exl}, 32'h1);
    rd(5'd14, "int_epc", 32'h0000_300C);
    rd(5'd13, "int_cause", 32'h8000_0000);
    step();
    check("int_ex_wb_drop", {31'h0, ex_wb}, 32'h0);
    check("int_flush_drop", {31'h0, cp0_flush}, 32'h0);

    // mtc0 EPC, then eret
    cp0_we = 1'b1; cp0_rdc = 5'd14; wdata = 32'h0000_3020;
    step();
    cp0_we = 1'b0;
    rd(5'd14, "mtc0_epc", 32'h0000_3020);
    eret_flush = 1'b1;
    step();
    eret_flush = 1'b0;
    check("eret_pulse", {31'h0, cp0_eret}, 32'h1);
    check("eret_flush", {31'h0, cp0_flush}, 32'h1);
    check("eret_pc", exc_pc, 32'h0000_3020);
    check("eret_exl", {31'h0, cp0_exl}, 32'h0);
    step();
    check("eret_drop", {31'h0, cp0_eret}, 32'h0);

    // Halt, ignored INT while halted, resume
    ex = 1'b1; ex_code = 5'd1; pc_in = 32'h0000_3100;
    step();
    ex = 1'b0;
    check("hlt_pc", exc_pc, 32'h0000_4200);
    rd(5'd13, "hlt_cause", 32'h0000_0004);
    rd(5'd14, "hlt_epc", 32'h0000_3100);
    check("hlt_exl", {31'h0, cp0_exl}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        ex = 1'b1; ex_code = 5'd0;
      end else begin
        ex = 1'b0;
      end
      check("hlt_held", {31'h0, cp0_hlt}, 32'h1);
      step();
    end
    ex = 1'b0;
    check("hlt_after_int", {31'h0, cp0_hlt}, 32'h1);
    check("hlt_no_exwb", {31'h0, ex_wb}, 32'h0);
    ex = 1'b1; ex_code = 5'd2;
    step();
    ex = 1'b0;
    check("res_hlt", {31'h0, cp0_hlt}, 32'h0);
    check("res_eret", {31'h0, cp0_eret}, 32'h1);
    check("res_flush", {31'h0, cp0_flush}, 32'h1);
    check("res_pc", exc_pc, 32'h0000_3100);
    check("res_exl", {31'h0, cp0_exl}, 32'h0);
    step();
    check("res_drop", {31'h0, cp0_eret}, 32'h0);
    check("res_run", {31'h0, cp0_hlt}, 32'h0);

    // ex beats eret_flush and mtc0 in the same cycle
    ex = 1'b1; ex_code = 5'd0; pc_in = 32'h0000_3200; eret_flush = 1'b1;
    cp0_we = 1'b1; cp0_rdc = 5'd12; wdata = 32'h0;
    step();
    ex = 1'b0; eret_flush = 1'b0; cp0_we = 1'b0;
    check("prio_ex_wb", {31'h0, ex_wb}, 32'h1);
    check("prio_no_eret", {31'h0, cp0_eret}, 32'h0);
    check("prio_im", {24'h0, cp0_int_mask}, 32'hFF);
    check("prio_ie", {31'h0, cp0_ie}, 32'h1);
    rd(5'd14, "prio_epc", 32'h0000_3200);
    step();

    // mtc0 Status writes only IE/EXL/IM
    cp0_we = 1'b1; cp0_rdc = 5'd12; wdata = 32'hFFFF_0A02;
    step();
    cp0_we = 1'b0;
    rd(5'd12, "mtc0_status", 32'h0000_0A02);

    // Level-sensitive IP, not writable
    ext_int = 8'h81;
    step();
    check("ip_load", {24'h0, cp0_int_sig}, 32'h81);
    cp0_we = 1'b1; cp0_rdc = 5'd13; wdata = 32'h0;
    step();
    cp0_we = 1'b0;
    check("ip_keep", {24'h0, cp0_int_sig}, 32'h81);
    rd(5'd13, "cause_nowrite", 32'h0000_8100);

    // Reset while halted, with a resume request in the same cycle
    ex = 1'b1; ex_code = 5'd1; pc_in = 32'h0000_3300;
    step();
    check("hlt2", {31'h0, cp0_hlt}, 32'h1);
    rst = 1'b1; ex_code = 5'd2;
    step();
    rst = 1'b0; ex = 1'b0;
    check("rst_hlt_clr", {31'h0, cp0_hlt}, 32'h0);
    check("rst_no_eret", {31'h0, cp0_eret}, 32'h0);
    check("rst_no_flush", {31'h0, cp0_flush}, 32'h0);
    rd(5'd12, "rst2_status", 32'h0000_FF01);
    rd(5'd14, "rst2_epc", 32'h0);
    step();
    check("rst2_idle", {31'h0, cp0_eret | cp0_hlt | ex_wb}, 32'h0);
    check("rst2_ip", {24'h0, cp0_int_sig}, 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_4180, SHALL be the handler entry address for interrupt exceptions.
REQ-002 Parameter HLT_VECTOR, default 32'h0000_4200, SHALL be the halt-loop entry address.
REQ-003 clk  in  1  SHALL be the single clock; every state change occurs on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 ex  in  1 and ex_code  in  5  SHALL carry the exception request and its cause (0 INT, 1 HLT, 2 RESUME) from the control unit.
REQ-006 cp0_we  in  1, cp0_rdc  in  5, wdata  in  32  SHALL carry the mtc0 write enable, the CP0 register number and the write data.
REQ-007 eret_flush  in  1 and branch_delay  in  1  SHALL carry the eret request and the delay-slot flag for the current instruction.
REQ-008 pc_in  in  32  SHALL be the PC of the instruction making the request; ext_int  in  8  SHALL be the raw interrupt lines.
REQ-009 rdata  out  32  SHALL return the CP0 register selected by cp0_rdc.
REQ-010 ex_wb, cp0_flush, cp0_hlt, cp0_eret  out  1 each  SHALL be the pipeline redirect signals to the control unit.
REQ-011 cp0_ie, cp0_exl  out  1, cp0_int_mask, cp0_int_sig  out  8  SHALL expose Status.IE, Status.EXL, Status.IM and Cause.IP.
REQ-012 exc_pc  out  32  SHALL be the redirect target, valid whenever ex_wb, cp0_hlt or cp0_eret is high.

Function
REQ-013 The block SHALL hold Status (reg 12: IE bit0, EXL bit1, IM bits15:8), Cause (reg 13: ExcCode bits6:2, IP bits15:8, BD bit31) and EPC (reg 14). All other bits read 0, and unimplemented register numbers read 0.
REQ-014 rdata SHALL be combinational from current register contents; a write in cycle N is visible from cycle N+1, with no forwarding.
REQ-015 Cause.IP SHALL be loaded from ext_int every cycle (level-sensitive), and writes to IP SHALL be ignored.
REQ-016 mtc0 SHALL update only IE, EXL and IM in Status, nothing in Cause, and all 32 bits of EPC.
REQ-017 The FSM SHALL have the states RUN, EXC, HALT and RESUME.
REQ-018 RUN + ex + ex_code=0 -> EXC, with the following updates:
  - EPC = branch_delay ? pc_in-4 : pc_in
  - BD = branch_delay
  - ExcCode = 0
  - EXL = 1
REQ-019 EXC SHALL last one cycle with ex_wb=1, cp0_flush=1 and exc_pc=EXC_VECTOR, then return to RUN.
REQ-020 RUN + ex + ex_code=1 -> HALT, saving EPC and BD as in REQ-018, with ExcCode=1 and EXL=1.
REQ-021 In HALT, cp0_hlt SHALL be 1 and exc_pc SHALL be HLT_VECTOR every cycle.
REQ-022 HALT + ex + ex_code=1 or 2 -> RESUME. ex with ex_code=0 in HALT SHALL be ignored.
REQ-023 RESUME SHALL last one cycle with cp0_eret=1, cp0_flush=1, exc_pc=EPC and EXL cleared, then return to RUN.
REQ-024 RUN + eret_flush SHALL clear EXL and assert cp0_eret=1, cp0_flush=1 and exc_pc=EPC in the next cycle only.
REQ-025 Priority SHALL be ex > eret_flush > mtc0; a lower-priority request in the same cycle SHALL be dropped.
REQ-026 ex SHALL be ignored in EXC and RESUME, and whenever ex_wb is high.
REQ-027 Redirect outputs SHALL all be registered, giving a latency of 1 cycle from request to redirect.

Reset
REQ-028 rst SHALL set the following:
  - state RUN
  - Status = 32'h0000_FF01 (IE=1, EXL=0, IM all ones)
  - Cause = 0
  - EPC = 0
  - all 1-bit outputs = 0
REQ-029 rst SHALL override any request in the same cycle; a reset in HALT or EXC returns to RUN with no redirect pulse.

Structure
REQ-030 A shared package SHALL hold the CP0 register numbers (12, 13, 14), the EX_CODE_INT/HLT/RESUME constants and the FSM state encoding; the control unit imports the same package.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Reset, then read regs 12/13/14 -> 32'h0000_FF01, 0, 0.
REQ-033 ex=1, ex_code=0, pc_in=32'h0000_3010, branch_delay=1 -> next cycle:
  - ex_wb=1, exc_pc=32'h0000_4180
  - EPC=32'h0000_300C, BD=1, EXL=1
  - ex_wb=0 one cycle later
REQ-034 mtc0 reg14 = 32'h0000_3020, then eret_flush -> next cycle cp0_eret=1, exc_pc=32'h0000_3020, EXL=0.
REQ-035 ex_code=1 -> cp0_hlt held high across 10 cycles; ex_code=0 ignored; ex_code=2 -> one RESUME pulse, then RUN.
REQ-036 Same cycle ex(code 0) + eret_flush + mtc0 reg12 = 0 -> exception taken, Status.IM still 8'hFF.
REQ-037 ext_int=8'h81 -> cp0_int_sig=8'h81 next cycle; mtc0 reg13 = 0 -> IP unchanged.
